i2c_slave: RTL and testbench
============================

# i2c_slave

Parametrised I2C target (slave) with an internal byte register file, built as the counterpart of `i2c_master`. It decodes START/STOP/repeated-START, matches a 7-bit address, and accepts pointer-addressed writes. It answers reads from the register file with pointer auto-increment. It drives `sda` open-drain on the shared bus and gives the local host a registered read port and a per-byte write strobe.

## Interface
- `SLV_ADDR`, 7'h2D: 7-bit bus address the block ACKs.
- `REG_DEPTH`, 16: register file depth; power of 2, 2..256. `AW = log2(REG_DEPTH)`.
- `SYNC_STG`, 2: synchroniser flops on `scl` and `sda`, 2..3.
- `clk`  in  1: system clock. Requires at least 16 clk periods per SCL period.
- `rstn`  in  1: asynchronous, active-low reset.
- `scl`  in  1: bus clock. The block never stretches the clock.
- `sda`  inout  1: bus data. The block drives only 1'b0, otherwise 1'bz.
- `host_addr`  in  AW: host read index.
- `host_rdata`  out  8: `reg[host_addr]`, registered, 1-cycle latency.
- `wr_stb`  out  1: 1-cycle pulse when a bus write data byte is committed.
- `wr_addr`  out  AW: register index of that write.
- `wr_data`  out  8: data of that write.
- `slv_status`  out  8:
  - [7] busy: addressed, between ACKed address and STOP/START.
  - [6] rw of the last matched transaction.
  - [5] master NACK ended the last read.
  - [4] address mismatch seen since the last match.
  - [3:0] 0.

## Operation
- `scl`/`sda` pass through SYNC_STG flops. Edges are detected on the synchronised values.
  - START: `sda` fall while `scl`=1.
  - STOP: `sda` rise while `scl`=1.
- Bus bits are sampled on `scl` rise. `sda` is changed on `scl` fall, in the cycle after fall detection.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits, MSB first. On the 8th rise, compare [7:1] with SLV_ADDR.
    - Match goes to ADDR_ACK.
    - Mismatch sets status[4] and goes to WAIT_STOP without driving.
  - ADDR_ACK: drive 0 for the 9th bit.
    - rw=0 goes to WR_BYTE with `first`=1.
    - rw=1 loads shift reg = `reg[ptr]` and goes to RD_BYTE.
  - WR_BYTE: shift 8 bits, then go to WR_ACK and drive 0.
    - `first`=1: `ptr <= byte[AW-1:0]` (upper bits ignored), `first`=0.
    - Otherwise: `reg[ptr] <= byte`, `wr_stb` pulses with the old `ptr`, then `ptr <= ptr+1` mod REG_DEPTH.
    - The commit happens on the clk after the 8th `scl` rise.
  - RD_BYTE: drive shift reg MSB first; release for the 9th bit, then go to RD_ACK.
  - RD_ACK: sample on the 9th rise.
    - 0: `ptr++`, reload `reg[ptr]`, go to RD_BYTE.
    - 1: set status[5], go to WAIT_STOP.
  - WAIT_STOP: release `sda`; only START or STOP is acted on.
- START in any state clears the bit counter, discards any partial byte, releases `sda`, and goes to ADDR.
  - `ptr` is kept, so a repeated-START read follows a pointer write.
- STOP in any state goes to IDLE, clears status[7], releases `sda`.
- status[5:4] clear on the next address match. status[6] updates on each match.

## Timing
- Reset values:
  - all outputs 0.
  - `sda` released (z).
  - state IDLE, `ptr` 0, register file 0.
- Reset asserted mid-transfer releases `sda` asynchronously.
- Detection latency: a bus edge is seen SYNC_STG+1 clk after it occurs.
- ACK drive starts within SYNC_STG+2 clk of the 8th `scl` fall. It is held until the 9th `scl` fall is detected.
- `wr_stb` is exactly 1 clk wide, with `wr_addr`/`wr_data` valid in the same cycle.
- `host_rdata` reflects a bus write on the clk after `wr_stb`.
- Simultaneous START and STOP detection cannot occur; START has priority in the encoding.
- `ptr` wraps from REG_DEPTH-1 to 0 on both read and write.

## Structure
- Package `i2c_pkg`:
  - state enum: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
  - status bit index constants.
  - ACK/NACK constants.
  - shared with `i2c_master`.
- Sub-module `i2c_sync_edge`: parametrised synchroniser plus rise/fall detect. Instantiated once each for `scl` and `sda`.
- Register file is a flop array in the top level.

## Test plan
- Write `[0x5A, 0x03, 0x11, 0x22]` (address 0x2D W):
  - ACK on all 4 bytes.
  - `wr_stb` ×2 with (3, 0x11) then (4, 0x22).
  - `host_rdata` at addr 4 = 0x22.
- Write pointer 0x03, repeated START, read 3 bytes, NACK on the last:
  - returns 0x11, 0x22, 0x00.
  - status[5]=1 after STOP, status[7]=0.
- Address 0x2C:
  - no ACK (`sda` stays z through the 9th bit).
  - status[4]=1.
  - subsequent bytes ignored until STOP.
- REG_DEPTH=16, pointer 0x1F, write 0xAA, 0xBB:
  - `wr_stb` at index 15 then 0 (wrap; pointer upper bits dropped).
- START mid-data-byte (after 4 bits):
  - partial byte discarded, no `wr_stb`.
  - new address phase ACKed normally.
- `rstn` pulled low during an ACK bit:
  - `sda` released immediately.
  - all outputs 0.
  - next transaction behaves as from reset.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: protocol states, status bit positions and ACK levels.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WR_BYTE   = 3'd3,
    WR_ACK    = 3'd4,
    RD_BYTE   = 3'd5,
    RD_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } i2c_state_e;

  localparam int STAT_BUSY = 7;
  localparam int STAT_RW   = 6;
  localparam int STAT_NACK = 5;
  localparam int STAT_MISM = 4;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  function automatic logic addr_hit(input logic [7:0] addr_byte, input logic [6:0] own_addr);
    return (addr_byte[7:1] == own_addr);
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchroniser for an asynchronous bus line with rise/fall detect.
module i2c_sync_edge #(
  parameter int STG = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STG-1:0] sync_r;
  logic           prev_r;

  // Idle bus level is high, so reset to 1 to avoid phantom edges
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_r <= '1;
      prev_r <= 1'b1;
    end else begin
      sync_r <= {sync_r[STG-2:0], d};
      prev_r <= sync_r[STG-1];
    end
  end

  assign q    = sync_r[STG-1];
  assign rise = q & ~prev_r;
  assign fall = ~q & prev_r;

endmodule

// File: rtl/i2c_slave.sv
// I2C target with a byte register file, pointer-addressed writes and
// auto-incrementing reads; sda is only ever pulled low.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLV_ADDR  = 7'h2D,
  parameter int         REG_DEPTH = 16,
  parameter int         SYNC_STG  = 2,
  localparam int        AW        = $clog2(REG_DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          scl,
  inout  wire           sda,
  input  logic [AW-1:0] host_addr,
  output logic [7:0]    host_rdata,
  output logic          wr_stb,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic [7:0]    slv_status
);

  logic scl_q_s, scl_rise_s, scl_fall_s;
  logic sda_q_s, sda_rise_s, sda_fall_s;
  logic start_s, stop_s;

  i2c_state_e    state_r, state_nxt_s;
  logic [3:0]    bit_cnt_r, bit_cnt_nxt_s;
  logic [7:0]    shift_r, shift_nxt_s;
  logic          sda_oe_r, sda_oe_nxt_s;
  logic [AW-1:0] ptr_r, ptr_nxt_s, ptr_inc_s;
  logic          first_r, first_nxt_s;
  logic [7:0]    stat_r, stat_nxt_s;
  logic          reg_we_s;
  logic [7:0]    byte_s, rd_cur_s, rd_inc_s;
  logic          wr_stb_r;
  logic [AW-1:0] wr_addr_r;
  logic [7:0]    wr_data_r, host_rdata_r;
  logic [7:0]    regs_r [REG_DEPTH];

  i2c_sync_edge #(.STG(SYNC_STG)) u_scl_sync (
    .clk(clk), .rstn(rstn), .d(scl), .q(scl_q_s), .rise(scl_rise_s), .fall(scl_fall_s)
  );

  i2c_sync_edge #(.STG(SYNC_STG)) u_sda_sync (
    .clk(clk), .rstn(rstn), .d(sda), .q(sda_q_s), .rise(sda_rise_s), .fall(sda_fall_s)
  );

  assign start_s   = sda_fall_s & scl_q_s;
  assign stop_s    = sda_rise_s & scl_q_s;
  assign byte_s    = {shift_r[6:0], sda_q_s};
  assign ptr_inc_s = ptr_r + AW'(1'b1);
  assign rd_cur_s  = regs_r[ptr_r];
  assign rd_inc_s  = regs_r[ptr_inc_s];

  // Next-state and datapath decode; bus conditions override every state
  always_comb begin
    state_nxt_s   = state_r;
    bit_cnt_nxt_s = bit_cnt_r;
    shift_nxt_s   = shift_r;
    sda_oe_nxt_s  = sda_oe_r;
    ptr_nxt_s     = ptr_r;
    first_nxt_s   = first_r;
    stat_nxt_s    = stat_r;
    reg_we_s      = 1'b0;
    if (start_s) begin
      state_nxt_s           = ADDR;
      bit_cnt_nxt_s         = 4'd0;
      sda_oe_nxt_s          = 1'b0;
      stat_nxt_s[STAT_BUSY] = 1'b0;
    end else if (stop_s) begin
      state_nxt_s           = IDLE;
      bit_cnt_nxt_s         = 4'd0;
      sda_oe_nxt_s          = 1'b0;
      stat_nxt_s[STAT_BUSY] = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          sda_oe_nxt_s = 1'b0;
        end
        ADDR: begin
          if (scl_rise_s) begin
            shift_nxt_s   = byte_s;
            bit_cnt_nxt_s = bit_cnt_r + 4'd1;
            if (bit_cnt_r == 4'd7 && addr_hit(byte_s, SLV_ADDR)) begin
              state_nxt_s           = ADDR_ACK;
              first_nxt_s           = 1'b1;
              stat_nxt_s[STAT_BUSY] = 1'b1;
              stat_nxt_s[STAT_RW]   = byte_s[0];
              stat_nxt_s[STAT_NACK] = 1'b0;
              stat_nxt_s[STAT_MISM] = 1'b0;
            end else if (bit_cnt_r == 4'd7) begin
              state_nxt_s           = WAIT_STOP;
              stat_nxt_s[STAT_MISM] = 1'b1;
            end else begin
              state_nxt_s = ADDR;
            end
          end else begin
            state_nxt_s = ADDR;
          end
        end
        ADDR_ACK, WR_ACK: begin
          // bit_cnt is 8 on the fall that opens the ACK slot, 9 on the one closing it
          if (scl_fall_s && bit_cnt_r == 4'd8) begin
            sda_oe_nxt_s = ~I2C_ACK;
          end else if (scl_fall_s) begin
            bit_cnt_nxt_s = 4'd0;
            if (state_r == ADDR_ACK && stat_r[STAT_RW]) begin
              state_nxt_s  = RD_BYTE;
              shift_nxt_s  = rd_cur_s;
              sda_oe_nxt_s = ~rd_cur_s[7];
            end else begin
              state_nxt_s  = WR_BYTE;
              sda_oe_nxt_s = 1'b0;
            end
          end else if (scl_rise_s) begin
            bit_cnt_nxt_s = 4'd9;
          end else begin
            bit_cnt_nxt_s = bit_cnt_r;
          end
        end
        WR_BYTE: begin
          if (scl_rise_s) begin
            shift_nxt_s   = byte_s;
            bit_cnt_nxt_s = bit_cnt_r + 4'd1;
            if (bit_cnt_r == 4'd7 && first_r) begin
              state_nxt_s = WR_ACK;
              ptr_nxt_s   = byte_s[AW-1:0];
              first_nxt_s = 1'b0;
            end else if (bit_cnt_r == 4'd7) begin
              state_nxt_s = WR_ACK;
              reg_we_s    = 1'b1;
              ptr_nxt_s   = ptr_inc_s;
            end else begin
              state_nxt_s = WR_BYTE;
            end
          end else begin
            state_nxt_s = WR_BYTE;
          end
        end
        RD_BYTE: begin
          if (scl_fall_s && bit_cnt_r == 4'd8) begin
            sda_oe_nxt_s = 1'b0;
            state_nxt_s  = RD_ACK;
          end else if (scl_fall_s) begin
            sda_oe_nxt_s = ~shift_r[7];
          end else if (scl_rise_s) begin
            bit_cnt_nxt_s = bit_cnt_r + 4'd1;
            shift_nxt_s   = {shift_r[6:0], 1'b0};
          end else begin
            shift_nxt_s = shift_r;
          end
        end
        RD_ACK: begin
          if (scl_rise_s && sda_q_s == I2C_ACK) begin
            ptr_nxt_s     = ptr_inc_s;
            shift_nxt_s   = rd_inc_s;
            bit_cnt_nxt_s = 4'd0;
            state_nxt_s   = RD_BYTE;
          end else if (scl_rise_s) begin
            stat_nxt_s[STAT_NACK] = 1'b1;
            state_nxt_s           = WAIT_STOP;
          end else begin
            state_nxt_s = RD_ACK;
          end
        end
        WAIT_STOP: begin
          sda_oe_nxt_s = 1'b0;
        end
        default: begin
          state_nxt_s  = IDLE;
          sda_oe_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // Protocol state, pointer, status and write-strobe registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= IDLE;
      bit_cnt_r <= 4'd0;
      shift_r   <= 8'h00;
      sda_oe_r  <= 1'b0;
      ptr_r     <= '0;
      first_r   <= 1'b0;
      stat_r    <= 8'h00;
      wr_stb_r  <= 1'b0;
      wr_addr_r <= '0;
      wr_data_r <= 8'h00;
    end else begin
      state_r   <= state_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      shift_r   <= shift_nxt_s;
      sda_oe_r  <= sda_oe_nxt_s;
      ptr_r     <= ptr_nxt_s;
      first_r   <= first_nxt_s;
      stat_r    <= stat_nxt_s;
      wr_stb_r  <= reg_we_s;
      if (reg_we_s) begin
        wr_addr_r <= ptr_r;
        wr_data_r <= byte_s;
      end
    end
  end

  // Register file and registered host read port
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < REG_DEPTH; i++) regs_r[i] <= 8'h00;
      host_rdata_r <= 8'h00;
    end else begin
      if (reg_we_s) regs_r[ptr_r] <= byte_s;
      host_rdata_r <= regs_r[host_addr];
    end
  end

  assign sda        = sda_oe_r ? 1'b0 : 1'bz;
  assign host_rdata = host_rdata_r;
  assign wr_stb     = wr_stb_r;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;
  assign slv_status = stat_r;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bus-master bench for i2c_slave; write strobes are checked by a
// scoreboard monitor, bus responses and host-side values inline.
module tb_i2c_slave;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rstn;
  logic       scl;
  logic       m_sda_oe;
  logic [3:0] host_addr;
  logic [7:0] host_rdata;
  logic       wr_stb;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] slv_status;
  wire        sda;

  assign sda = m_sda_oe ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave #(.SLV_ADDR(7'h2D), .REG_DEPTH(16), .SYNC_STG(2)) dut (
    .clk(clk), .rstn(rstn), .scl(scl), .sda(sda), .host_addr(host_addr),
    .host_rdata(host_rdata), .wr_stb(wr_stb), .wr_addr(wr_addr),
    .wr_data(wr_data), .slv_status(slv_status)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (wr_stb === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL wr_stb_unexpected: got addr=%0d data=0x%0h expected none", wr_addr, wr_data);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          n_errors++;
          $display("FAIL wr_stb: got addr=%0d data=0x%0h expected addr=%0d data=0x%0h",
                   wr_addr, wr_data, e[11:8], e[7:0]);
        end
      end
    end
  end

  function automatic logic bus_level();
    return (sda === 1'b0) ? 1'b0 : 1'b1;
  endfunction

  task automatic wait_q();
    repeat (Q) @(posedge clk);
  endtask

  task automatic bus_start();
    m_sda_oe = 1'b0; wait_q();
    scl = 1'b1;      wait_q();
    m_sda_oe = 1'b1; wait_q();
    scl = 1'b0;      wait_q();
  endtask

  task automatic bus_stop();
    m_sda_oe = 1'b1; wait_q();
    scl = 1'b1;      wait_q();
    m_sda_oe = 1'b0; wait_q();
  endtask

  task automatic send_bit(input logic b);
    m_sda_oe = ~b; wait_q();
    scl = 1'b1;    wait_q(); wait_q();
    scl = 1'b0;    wait_q();
  endtask

  task automatic read_bit(output logic b);
    m_sda_oe = 1'b0; wait_q();
    scl = 1'b1;      wait_q();
    #1 b = bus_level();
    wait_q();
    scl = 1'b0;      wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic nack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    read_bit(nack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack_bit);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    send_bit(ack_bit);
  endtask

  task automatic wr_chk(input string name, input logic [7:0] d, input logic exp_nack);
    logic nack;
    write_byte(d, nack);
    check(name, 32'(nack), 32'(exp_nack));
  endtask

  task automatic host_chk(input string name, input logic [3:0] a, input logic [7:0] exp);
    host_addr = a;
    repeat (2) @(posedge clk);
    #1 check(name, 32'(host_rdata), 32'(exp));
  endtask

  initial begin
    logic [7:0] rd;
    logic [7:0] pat;
    rstn = 1'b0; scl = 1'b1; m_sda_oe = 1'b0; host_addr = 4'd0;
    repeat (5) @(posedge clk);
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_status", 32'(slv_status), 32'h00);
    check("rst_wr_stb", 32'(wr_stb), 32'h0);
    check("rst_wr_addr", 32'(wr_addr), 32'h0);
    check("rst_wr_data", 32'(wr_data), 32'h00);
    check("rst_rdata", 32'(host_rdata), 32'h00);
    check("rst_sda", 32'(bus_level()), 32'h1);

    // Pointer write then two data bytes
    bus_start();
    wr_chk("w1_addr_ack", 8'h5A, 1'b0);
    check("w1_busy", 32'(slv_status), 32'h80);
    wr_chk("w1_ptr_ack", 8'h03, 1'b0);
    exp_q.push_back({4'd3, 8'h11});
    wr_chk("w1_d0_ack", 8'h11, 1'b0);
    exp_q.push_back({4'd4, 8'h22});
    wr_chk("w1_d1_ack", 8'h22, 1'b0);
    bus_stop();
    check("w1_status", 32'(slv_status), 32'h00);
    host_chk("w1_host4", 4'd4, 8'h22);
    host_chk("w1_host3", 4'd3, 8'h11);

    // Pointer write, repeated START, 3-byte read ending with NACK
    bus_start();
    wr_chk("r1_waddr_ack", 8'h5A, 1'b0);
    wr_chk("r1_ptr_ack", 8'h03, 1'b0);
    bus_start();
    wr_chk("r1_raddr_ack", 8'h5B, 1'b0);
    check("r1_busy_rd", 32'(slv_status), 32'hC0);
    read_byte(rd, 1'b0); check("r1_byte0", 32'(rd), 32'h11);
    read_byte(rd, 1'b0); check("r1_byte1", 32'(rd), 32'h22);
    read_byte(rd, 1'b1); check("r1_byte2", 32'(rd), 32'h00);
    bus_stop();
    check("r1_status", 32'(slv_status), 32'h60);

    // Foreign address: no ACK, following bytes ignored
    bus_start();
    wr_chk("mm_addr_nack", 8'h58, 1'b1);
    check("mm_status", 32'(slv_status), 32'h70);
    wr_chk("mm_data_nack", 8'h01, 1'b1);
    bus_stop();
    check("mm_status_stop", 32'(slv_status), 32'h70);

    // Out-of-range pointer keeps low bits and wraps after index 15
    bus_start();
    wr_chk("wrap_addr_ack", 8'h5A, 1'b0);
    check("wrap_status_clr", 32'(slv_status), 32'h80);
    wr_chk("wrap_ptr_ack", 8'h1F, 1'b0);
    exp_q.push_back({4'd15, 8'hAA});
    wr_chk("wrap_d0_ack", 8'hAA, 1'b0);
    exp_q.push_back({4'd0, 8'hBB});
    wr_chk("wrap_d1_ack", 8'hBB, 1'b0);
    bus_stop();
    host_chk("wrap_host15", 4'd15, 8'hAA);
    host_chk("wrap_host0", 4'd0, 8'hBB);

    // START after 4 data bits discards the partial byte
    bus_start();
    wr_chk("ps_addr_ack", 8'h5A, 1'b0);
    wr_chk("ps_ptr_ack", 8'h02, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    bus_start();
    wr_chk("ps_readdr_ack", 8'h5A, 1'b0);
    wr_chk("ps_ptr2_ack", 8'h07, 1'b0);
    exp_q.push_back({4'd7, 8'h77});
    wr_chk("ps_d0_ack", 8'h77, 1'b0);
    host_chk("ps_host2", 4'd2, 8'h00);
    host_chk("ps_host7", 4'd7, 8'h77);

    // Reset while the slave is driving the address ACK
    bus_start();
    pat = 8'h5A;
    for (int i = 7; i >= 0; i--) send_bit(pat[i]);
    m_sda_oe = 1'b0;
    repeat (Q) @(posedge clk);
    #2 check("ra_ack_drive", 32'(bus_level()), 32'h0);
    check("ra_busy", 32'(slv_status), 32'h80);
    #1 rstn = 1'b0;
    #1 check("ra_sda_release", 32'(bus_level()), 32'h1);
    check("ra_status", 32'(slv_status), 32'h00);
    check("ra_wr_addr", 32'(wr_addr), 32'h0);
    check("ra_wr_data", 32'(wr_data), 32'h00);
    check("ra_rdata", 32'(host_rdata), 32'h00);
    repeat (4) @(posedge clk);
    rstn = 1'b1;
    bus_stop();
    host_chk("ra_regs_clr", 4'd0, 8'h00);
    bus_start();
    wr_chk("ra_raddr_ack", 8'h5B, 1'b0);
    read_byte(rd, 1'b1); check("ra_read0", 32'(rd), 32'h00);
    bus_stop();
    check("ra_status_rd", 32'(slv_status), 32'h60);
    bus_start();
    wr_chk("ra_waddr_ack", 8'h5A, 1'b0);
    wr_chk("ra_ptr_ack", 8'h00, 1'b0);
    exp_q.push_back({4'd0, 8'h44});
    wr_chk("ra_d0_ack", 8'h44, 1'b0);
    bus_stop();
    host_chk("ra_host0", 4'd0, 8'h44);

    repeat (10) @(posedge clk);
    check("wr_q_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
